// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port synchronous RAM: data port has fixed
// priority, a starvation counter bounds how long instruction fetch can wait.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_ONE    = LAT_W'(1);
  localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [SC_W-1:0]  SC_ONE     = SC_W'(1);
  localparam logic OWN_DM = 1'b0;
  localparam logic OWN_IF = 1'b1;

  logic [1:0]        state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              issue;

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_rvalid_d  = 1'b0;
    dm_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    case (state_q)
      S_IDLE: begin
        // The guard keeps the count at or below STARVE_MAX, so it saturates there.
        if (dm_req && (starve_cnt_q < STARVE_LIM)) begin
          state_d      = S_ISSUE;
          owner_d      = OWN_DM;
          we_d         = dm_we;
          addr_d       = dm_addr;
          wdata_d      = dm_wdata;
          starve_cnt_d = if_req ? starve_cnt_q + SC_ONE : '0;
        end else if (if_req) begin
          state_d      = S_ISSUE;
          owner_d      = OWN_IF;
          we_d         = 1'b0;
          addr_d       = if_addr;
          starve_cnt_d = '0;
        end else if (dm_req) begin
          state_d      = S_ISSUE;
          owner_d      = OWN_DM;
          we_d         = dm_we;
          addr_d       = dm_addr;
          wdata_d      = dm_wdata;
          starve_cnt_d = '0;
        end else begin
          starve_cnt_d = '0;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else if (MEM_LAT == 1) begin
          state_d = S_RESP;
        end else begin
          state_d   = S_WAIT;
          lat_cnt_d = LAT_INIT;
        end
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q - LAT_ONE;
        if (lat_cnt_d == '0) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (owner_q == OWN_IF) begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata;
        end else begin
          dm_rvalid_d = 1'b1;
          dm_rdata_d  = mem_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      owner_q      <= OWN_DM;
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      if_rvalid_q  <= if_rvalid_d;
      dm_rvalid_q  <= dm_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  // Captured request fields need no reset: every RAM-facing use is gated by issue.
  always_ff @(posedge clock) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign issue     = (state_q == S_ISSUE);
  assign mem_en    = issue;
  assign mem_we    = issue & we_q;
  assign mem_addr  = issue ? addr_q : '0;
  assign mem_wdata = issue ? wdata_q : '0;
  assign if_gnt    = issue & (owner_q == OWN_IF);
  assign dm_gnt    = issue & (owner_q == OWN_DM);
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM model, transaction-level reference schedule,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int ML = 2;
  localparam int SM = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(ML), .STARVE_MAX(SM)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // RAM with two-cycle read latency; drives junk whenever no read data is due
  logic [DW-1:0] ram [0:255] = '{default: 64'h0};
  logic          rd_v1 = 1'b0, rd_v2 = 1'b0;
  logic [DW-1:0] rd_d1, rd_d2, junk;
  always @(posedge clock) begin
    if (mem_en && mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    rd_v1 <= mem_en && !mem_we;
    rd_d1 <= ram[mem_addr[7:0]];
    rd_v2 <= rd_v1;
    rd_d2 <= rd_d1;
    junk  <= {$urandom, $urandom};
  end
  assign mem_rdata = rd_v2 ? rd_d2 : junk;

  logic any_out;
  assign any_out = |{if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
                     mem_en, mem_we, mem_addr, mem_wdata, busy};

  // Expected outputs per cycle slot (slot n = interval after rising edge n)
  typedef struct packed {
    logic          rst, en, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ig, dg, irv, drv, bsy;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t          ring [16];
  logic [DW-1:0] model_mem [256];
  logic [DW-1:0] m_if_rdata, m_dm_rdata;
  int slot, next_dec, starve, if_gnt_slot, dm_gnt_slot;
  int n_cmp, n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s slot=%0d: got %h expected %h", name, slot, act, expv);
    end
  endtask

  // Applies the arbitration rules to the inputs the coming edge will sample.
  task automatic model_edge();
    int e, win;
    logic [AW-1:0] a;
    e = slot + 1;
    if (reset) begin
      for (int i = 0; i < 16; i++) ring[i] = '0;
      ring[e % 16].rst = 1'b1;
      m_if_rdata = '0;
      m_dm_rdata = '0;
      starve = 0;
      next_dec = e + 1;
      return;
    end
    if (e < next_dec) return;
    if (dm_req && starve < SM) begin
      win = 1;
      starve = if_req ? ((starve + 1 > SM) ? SM : starve + 1) : 0;
    end else if (if_req) begin
      win = 2; starve = 0;
    end else if (dm_req) begin
      win = 1; starve = 0;
    end else begin
      win = 0; starve = 0;
    end
    if (win == 0) begin
      next_dec = e + 1;
      return;
    end
    ring[e % 16].en  = 1'b1;
    ring[e % 16].bsy = 1'b1;
    if (win == 1) begin
      a = dm_addr;
      ring[e % 16].dg    = 1'b1;
      ring[e % 16].we    = dm_we;
      ring[e % 16].wdata = dm_wdata;
      dm_gnt_slot = e;
    end else begin
      a = if_addr;
      ring[e % 16].ig = 1'b1;
      if_gnt_slot = e;
    end
    ring[e % 16].addr = a;
    if (win == 1 && dm_we) begin
      model_mem[a[7:0]] = dm_wdata;
      next_dec = e + 2;
    end else begin
      for (int k = 1; k <= ML; k++) ring[(e + k) % 16].bsy = 1'b1;
      if (win == 1) ring[(e + ML + 1) % 16].drv = 1'b1;
      else          ring[(e + ML + 1) % 16].irv = 1'b1;
      ring[(e + ML + 1) % 16].rdata = model_mem[a[7:0]];
      next_dec = e + ML + 2;
    end
  endtask

  task automatic compare_slot();
    exp_t x;
    x = ring[slot % 16];
    if (x.irv) m_if_rdata = x.rdata;
    if (x.drv) m_dm_rdata = x.rdata;
    chk("busy", busy, x.bsy);
    chk("mem_en", mem_en, x.en);
    chk("if_gnt", if_gnt, x.ig);
    chk("dm_gnt", dm_gnt, x.dg);
    chk("if_rvalid", if_rvalid, x.irv);
    chk("dm_rvalid", dm_rvalid, x.drv);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("dm_rdata", dm_rdata, m_dm_rdata);
    if (x.en) begin
      chk("mem_we", mem_we, x.we);
      chk("mem_addr", mem_addr, x.addr);
      if (x.we) chk("mem_wdata", mem_wdata, x.wdata);
    end
    if (x.rst) chk("reset_outputs", any_out, 1'b0);
    ring[slot % 16] = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    @(negedge clock);
    slot++;
    compare_slot();
  endtask

  task automatic idle(input int n);
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int g, seen;
    logic [5:0] seq;
    logic if_pend, dm_pend;
    n_cmp = 0; n_fail = 0; slot = 0; next_dec = 0; starve = 0;
    if_gnt_slot = -1; dm_gnt_slot = -1;
    m_if_rdata = '0; m_dm_rdata = '0;
    for (int i = 0; i < 16; i++) ring[i] = '0;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    tick();
    chk("rst_all_zero", any_out, 1'b0);
    reset = 1'b0;
    idle(2);

    // IF read of 0x0010 after storing 0xDEAD there
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0010; dm_wdata = 64'hDEAD;
    tick();
    chk("t1_store_gnt", dm_gnt, 1'b1);
    idle(3);
    if_req = 1'b1; if_addr = 16'h0010;
    tick();
    chk("t1_if_gnt", if_gnt, 1'b1);
    chk("t1_mem_addr", mem_addr, 16'h0010);
    if_req = 1'b0;
    tick(); tick();
    chk("t1_no_early_rvalid", if_rvalid, 1'b0);
    tick();
    chk("t1_if_rvalid", if_rvalid, 1'b1);
    chk("t1_if_rdata", if_rdata, 64'hDEAD);
    idle(2);

    // Store 0xBEEF @0x20 then load it back
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0020; dm_wdata = 64'hBEEF;
    tick();
    chk("t3_store_we", mem_we, 1'b1);
    chk("t3_store_wdata", mem_wdata, 64'hBEEF);
    dm_we = 1'b0;
    tick();
    chk("t3_gap_no_en", mem_en, 1'b0);
    tick();
    chk("t3_load_gnt", dm_gnt, 1'b1);
    chk("t3_load_we", mem_we, 1'b0);
    dm_req = 1'b0;
    tick(); tick(); tick();
    chk("t3_dm_rvalid", dm_rvalid, 1'b1);
    chk("t3_dm_rdata", dm_rdata, 64'hBEEF);
    idle(2);

    // Simultaneous IF and DM reads
    if_req = 1'b1; if_addr = 16'h0010;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0020;
    tick();
    chk("t2_dm_first", dm_gnt, 1'b1);
    chk("t2_if_waits", if_gnt, 1'b0);
    dm_req = 1'b0;
    tick(); tick(); tick();
    chk("t2_dm_rvalid", dm_rvalid, 1'b1);
    chk("t2_dm_rdata", dm_rdata, 64'hBEEF);
    chk("t2_if_rvalid_quiet", if_rvalid, 1'b0);
    tick();
    chk("t2_if_gnt", if_gnt, 1'b1);
    if_req = 1'b0;
    tick(); tick(); tick();
    chk("t2_if_rvalid", if_rvalid, 1'b1);
    chk("t2_if_rdata", if_rdata, 64'hDEAD);
    chk("t2_dm_rvalid_quiet", dm_rvalid, 1'b0);
    idle(2);

    // IF request withdrawn before any decision edge sees it
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0020;
    tick();
    chk("t6_dm_gnt", dm_gnt, 1'b1);
    dm_req = 1'b0; if_req = 1'b1; if_addr = 16'h0030;
    tick(); tick();
    if_req = 1'b0;
    seen = 0;
    repeat (6) begin
      tick();
      if (if_gnt || mem_en) seen++;
    end
    chk("t6_no_issue", seen, 0);
    idle(2);

    // Both requests held: four DM wins, then IF is forced
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0040; dm_wdata = 64'h1234;
    if_req = 1'b1; if_addr = 16'h0010;
    g = 0; seq = '0;
    for (int i = 0; i < 60 && g < 6; i++) begin
      tick();
      if (dm_gnt) g++;
      else if (if_gnt) begin
        seq[g] = 1'b1;
        g++;
      end
    end
    chk("t4_grant_count", g, 6);
    chk("t4_grant_order", seq, 6'b010000);
    idle(6);

    // Reset while a read is waiting on the RAM
    if_req = 1'b1; if_addr = 16'h0010;
    tick();
    chk("t5_if_gnt", if_gnt, 1'b1);
    if_req = 1'b0;
    tick();
    chk("t5_busy_wait", busy, 1'b1);
    reset = 1'b1;
    tick();
    chk("t5_all_zero", any_out, 1'b0);
    reset = 1'b0;
    seen = 0;
    repeat (8) begin
      tick();
      if (if_rvalid) seen++;
    end
    chk("t5_no_rvalid", seen, 0);
    idle(2);

    // Randomized traffic with withdrawals and occasional resets
    if_pend = 1'b0; dm_pend = 1'b0;
    repeat (3000) begin
      if (if_gnt_slot == slot) if_pend = 1'b0;
      if (dm_gnt_slot == slot) dm_pend = 1'b0;
      reset = ($urandom_range(0, 199) == 0);
      if (!if_pend) if_addr = AW'($urandom_range(0, 31));
      if (if_pend && $urandom_range(0, 15) == 0) if_pend = 1'b0;
      else if (!if_pend && $urandom_range(0, 2) == 0) if_pend = 1'b1;
      if (!dm_pend) begin
        dm_addr  = AW'($urandom_range(0, 31));
        dm_we    = $urandom_range(0, 1) == 1;
        dm_wdata = {$urandom, $urandom};
      end
      if (dm_pend && $urandom_range(0, 15) == 0) dm_pend = 1'b0;
      else if (!dm_pend && $urandom_range(0, 1) == 0) dm_pend = 1'b1;
      if_req = if_pend;
      dm_req = dm_pend;
      tick();
    end
    reset = 1'b0;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
